// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM encoding and flag helpers for the sequential ALU.
// Imported by seq_alu and seq_alu_muldiv.
package seq_alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_DIV = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_e;

   // Signed overflow from operand and result sign bits.
   function automatic logic ovf_f(
      input logic a,
      input logic b,
      input logic r,
      input logic sub
   );
      if (sub) return (a != b) && (r != a);
      return (a == b) && (r != a);
   endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider.
// Ports: start_i/div_i/a_i/b_i load; done_o marks the last step; hi_o/lo_o are next-state values.
module seq_alu_muldiv
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             div_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] hi_d;
   logic [WIDTH-1:0] lo_d;
   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   shf_w;
   logic [WIDTH:0]   dif_w;

   // One iteration: mul shifts {hi,lo} right adding b on lo[0];
   // div shifts the next dividend bit into the remainder and trial-subtracts.
   always_comb begin
      sum_w = {1'b0, hi_q} + {1'b0, b_q};
      shf_w = {hi_q, lo_q[WIDTH-1]};
      dif_w = shf_w - {1'b0, b_q};
      hi_d  = hi_q;
      lo_d  = lo_q;
      if (div_q) begin
         if (dif_w[WIDTH]) begin
            hi_d = shf_w[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end else begin
            hi_d = dif_w[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end
      end else if (lo_q[0]) begin
         {hi_d, lo_d} = {sum_w, lo_q[WIDTH-1:1]};
      end else begin
         {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         div_q  <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         b_q    <= '0;
      end else if (start_i) begin
         cnt_q  <= CW'(WIDTH);
         busy_q <= 1'b1;
         div_q  <= div_i;
         hi_q   <= '0;
         lo_q   <= a_i;
         b_q    <= b_i;
      end else if (busy_q) begin
         cnt_q <= cnt_q - CW'(1);
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         if (cnt_q == CW'(1)) busy_q <= 1'b0;
      end
   end

   // The step taken while the count is 1 is the last; its result is final.
   assign done_o = busy_q && (cnt_q == CW'(1));
   assign hi_o   = hi_d;
   assign lo_o   = lo_d;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes on input and output.
// Ports: in_valid/in_ready/A/B/ALU_Code in; out_valid/out_ready/ALU_Out/ALU_Hi/flags out.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_Code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_Out,
   output logic [WIDTH-1:0] ALU_Hi,
   output logic             Carry,
   output logic             Overflow,
   output logic             isZero,
   output logic             DivZero,
   output logic             Illegal
);

   state_e           state_q;
   logic [WIDTH-1:0] out_q, hi_q;
   logic             c_q, v_q, z_q, dz_q, il_q, mul_q;

   logic [WIDTH-1:0] res_d, hi_d;
   logic             c_d, v_d, dz_d, il_d;
   logic [WIDTH:0]   sum_w, dif_w, shl_w, shr_w;
   logic             is_md, md_start, md_done;
   logic [WIDTH-1:0] md_hi, md_lo;

   assign is_md = (ALU_Code == OP_MUL) ||
                  ((ALU_Code == OP_DIV) && (B != '0));
   assign md_start = (state_q == S_IDLE) && in_valid && is_md;

   always_comb begin
      sum_w = {1'b0, A} + {1'b0, B};
      dif_w = {1'b0, A} - {1'b0, B};
      // Extra bit catches the last bit shifted out; amount 0 leaves it 0.
      shl_w = {1'b0, A} << B[SHW-1:0];
      shr_w = {A, 1'b0} >> B[SHW-1:0];
      res_d = '0;
      hi_d  = '0;
      c_d   = 1'b0;
      v_d   = 1'b0;
      dz_d  = 1'b0;
      il_d  = 1'b0;
      unique case (ALU_Code)
         OP_ADD: begin
            res_d = sum_w[WIDTH-1:0];
            c_d   = sum_w[WIDTH];
            v_d   = ovf_f(A[WIDTH-1], B[WIDTH-1], sum_w[WIDTH-1], 1'b0);
         end
         OP_SUB: begin
            res_d = dif_w[WIDTH-1:0];
            c_d   = dif_w[WIDTH];
            v_d   = ovf_f(A[WIDTH-1], B[WIDTH-1], dif_w[WIDTH-1], 1'b1);
         end
         OP_AND: res_d = A & B;
         OP_OR:  res_d = A | B;
         OP_XOR: res_d = A ^ B;
         OP_SHL: begin
            res_d = shl_w[WIDTH-1:0];
            c_d   = shl_w[WIDTH];
         end
         OP_SHR: begin
            res_d = shr_w[WIDTH:1];
            c_d   = shr_w[0];
         end
         OP_NOT: res_d = ~A;
         OP_MUL: res_d = '0;
         OP_DIV: begin
            if (B == '0) begin
               res_d = '1;
               hi_d  = A;
               dz_d  = 1'b1;
            end
         end
         default: il_d = 1'b1;
      endcase
   end

   seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (md_start),
      .div_i   (ALU_Code == OP_DIV),
      .a_i     (A),
      .b_i     (B),
      .done_o  (md_done),
      .hi_o    (md_hi),
      .lo_o    (md_lo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         out_q   <= '0;
         hi_q    <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
         dz_q    <= 1'b0;
         il_q    <= 1'b0;
         mul_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  mul_q <= (ALU_Code == OP_MUL);
                  if (is_md) begin
                     state_q <= S_BUSY;
                     out_q   <= '0;
                     hi_q    <= '0;
                     c_q     <= 1'b0;
                     v_q     <= 1'b0;
                     z_q     <= 1'b0;
                     dz_q    <= 1'b0;
                     il_q    <= 1'b0;
                  end else begin
                     state_q <= S_DONE;
                     out_q   <= res_d;
                     hi_q    <= hi_d;
                     c_q     <= c_d;
                     v_q     <= v_d;
                     z_q     <= (res_d == '0);
                     dz_q    <= dz_d;
                     il_q    <= il_d;
                  end
               end
            end
            S_BUSY: begin
               if (md_done) begin
                  state_q <= S_DONE;
                  out_q   <= md_lo;
                  hi_q    <= md_hi;
                  c_q     <= mul_q && (md_hi != '0);
                  z_q     <= (md_lo == '0);
               end
            end
            S_DONE: begin
               if (out_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign ALU_Out   = out_q;
   assign ALU_Hi    = hi_q;
   assign Carry     = c_q;
   assign Overflow  = v_q;
   assign isZero    = z_q;
   assign DivZero   = dz_q;
   assign Illegal   = il_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (WIDTH=16).
// Checks results, flags, latency, backpressure and mid-operation reset.
module tb_seq_alu;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic [3:0]   ALU_Code = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] ALU_Out, ALU_Hi;
   logic         Carry, Overflow, isZero, DivZero, Illegal;

   int checks = 0;
   int errors = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .ALU_Code  (ALU_Code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALU_Out   (ALU_Out),
      .ALU_Hi    (ALU_Hi),
      .Carry     (Carry),
      .Overflow  (Overflow),
      .isZero    (isZero),
      .DivZero   (DivZero),
      .Illegal   (Illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] flags();
      return {Carry, Overflow, isZero, DivZero, Illegal};
   endfunction

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("issue_rdy", in_ready, 1);
      A = a;
      B = b;
      ALU_Code = op;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Latency = negedges after the accept edge until out_valid is seen.
   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 40);
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_vld_low"}, out_valid, 0);
      check({tag, "_rdy_back"}, in_ready, 1);
   endtask

   task automatic run(input string tag, input logic [3:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] e_out, input logic [W-1:0] e_hi,
                      input logic [4:0] e_fl, input int e_lat);
      int lat;
      issue(op, a, b);
      wait_valid(lat);
      check({tag, "_lat"}, lat, e_lat);
      check({tag, "_out"}, ALU_Out, e_out);
      check({tag, "_hi"}, ALU_Hi, e_hi);
      check({tag, "_flags"}, flags(), e_fl);
      release_out(tag);
   endtask

   initial begin
      int lat;
      int seen;
      logic [W-1:0] held;

      #12;
      check("rst_rdy", in_ready, 1);
      check("rst_vld", out_valid, 0);
      check("rst_out", ALU_Out, 0);
      check("rst_hi", ALU_Hi, 0);
      check("rst_flags", flags(), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // flags = {Carry, Overflow, isZero, DivZero, Illegal}
      run("add", 4'd0, 16'd5, 16'd2, 16'd7, 16'd0, 5'b00000, 1);
      run("sub", 4'd1, 16'h0003, 16'h0005, 16'hFFFE, 16'd0, 5'b10000, 1);
      run("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 16'd0, 5'b01000, 1);
      run("add_cz", 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'd0, 5'b10100, 1);
      run("sub_ovf", 4'd1, 16'h8000, 16'h0001, 16'h7FFF, 16'd0, 5'b01000, 1);
      run("and", 4'd2, 16'hF0F0, 16'hFF00, 16'hF000, 16'd0, 5'b00000, 1);
      run("or", 4'd3, 16'hF0F0, 16'h0F00, 16'hFFF0, 16'd0, 5'b00000, 1);
      run("xor", 4'd4, 16'hFFFF, 16'hFFFF, 16'h0000, 16'd0, 5'b00100, 1);
      run("not", 4'd7, 16'h00FF, 16'h1234, 16'hFF00, 16'd0, 5'b00000, 1);
      run("shl", 4'd5, 16'h8001, 16'h0001, 16'h0002, 16'd0, 5'b10000, 1);
      run("shl15", 4'd5, 16'h0003, 16'h000F, 16'h8000, 16'd0, 5'b10000, 1);
      run("shr0", 4'd6, 16'h0001, 16'h0000, 16'h0001, 16'd0, 5'b00000, 1);
      run("shr", 4'd6, 16'h0003, 16'h0001, 16'h0001, 16'd0, 5'b10000, 1);
      run("mul", 4'd8, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 5'b10000, 17);
      run("mul_max", 4'd8, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE,
          5'b10000, 17);
      run("mul_small", 4'd8, 16'd3, 16'd5, 16'd15, 16'd0, 5'b00000, 17);
      run("div", 4'd9, 16'd100, 16'd7, 16'd14, 16'd2, 5'b00000, 17);
      run("div_big", 4'd9, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F,
          5'b00000, 17);
      run("div0", 4'd9, 16'd9, 16'd0, 16'hFFFF, 16'd9, 5'b00010, 1);
      run("ill", 4'd12, 16'h1234, 16'h5678, 16'h0, 16'h0, 5'b00101, 1);

      // Backpressure with an ignored request pending.
      issue(4'd8, 16'd3, 16'd5);
      wait_valid(lat);
      check("bp_lat", lat, 17);
      held = ALU_Out;
      check("bp_out", held, 16'd15);
      A = 16'd1;
      B = 16'd1;
      ALU_Code = 4'd0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_vld", out_valid, 1);
         check("bp_rdy", in_ready, 0);
         check("bp_hold", ALU_Out, 16'd15);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("bp_one_xfer", seen, 0);
      check("bp_rdy_back", in_ready, 1);

      // Reset in the middle of a divide.
      issue(4'd9, 16'd100, 16'd7);
      repeat (8) @(negedge clk);
      check("mr_busy_vld", out_valid, 0);
      check("mr_busy_rdy", in_ready, 0);
      rst_n = 1'b0;
      #1;
      check("mr_rdy", in_ready, 1);
      check("mr_vld", out_valid, 0);
      check("mr_out", ALU_Out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("mr_no_result", seen, 0);
      run("mr_add", 4'd0, 16'd1, 16'd1, 16'd2, 16'd0, 5'b00000, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the CPU's combinational 16-bit ALU.
- Adds iterative multiply (shift-add) and divide (restoring) to the single-cycle logic/arithmetic ops.
- Wraps every operation in a valid/ready handshake on both input and output.
- Sits between the decode/register-read stage and writeback. The pipeline stalls on in_ready/out_valid instead of assuming a fixed latency.

Parameters:
WIDTH, 16, operand and result width in bits (≥4, power of two).
SHW, $clog2(WIDTH), shift-amount bits taken from B[SHW-1:0].

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands and opcode present.
in_ready  output  1  block can accept an operation.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
ALU_Code  input  4  opcode (encoding below).
out_valid  output  1  result registers hold a completed operation.
out_ready  input  1  consumer accepts the result.
ALU_Out  output  WIDTH  result, or product low word, or quotient.
ALU_Hi  output  WIDTH  product high word or remainder; 0 for other ops.
Carry  output  1  carry/borrow/shifted-out bit.
Overflow  output  1  signed overflow (ADD/SUB only).
isZero  output  1  ALU_Out == 0.
DivZero  output  1  DIV with B == 0.
Illegal  output  1  reserved opcode.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 NOT A.
  - 8 MUL (unsigned), 9 DIV (unsigned).
  - 10–15 reserved.
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: all outputs 0 except in_ready = 1.
- in_ready = 1 only in IDLE. An operation is accepted on a clock edge where in_valid && in_ready. A, B and ALU_Code are registered at that edge.
- Single-cycle ops (0–7, reserved, DIV-by-zero):
  - IDLE→DONE on the accept edge.
  - out_valid rises the cycle after accept (latency 1).
- MUL/DIV (B≠0):
  - IDLE→BUSY on accept.
  - A WIDTH-count down-counter runs one iteration per cycle.
  - BUSY→DONE on the cycle the count reaches 0.
  - out_valid rises exactly WIDTH+1 cycles after accept (17 for WIDTH=16).
- DONE:
  - All outputs held stable while out_valid && !out_ready.
  - On out_valid && out_ready: DONE→IDLE, out_valid falls. No back-to-back accept in the same edge; in_ready returns one cycle later.
- Arithmetic and flag rules:
  - ADD: Carry = carry out of bit WIDTH-1. Overflow = signed overflow.
  - SUB: A−B. Carry = borrow (A<B unsigned). Overflow = signed overflow.
  - SHL/SHR: amount = B[SHW-1:0]. Carry = last bit shifted out; amount 0 gives Carry 0.
  - AND, OR, XOR, NOT: Carry = Overflow = 0.
  - MUL: full 2·WIDTH product in {ALU_Hi, ALU_Out}. Carry = (ALU_Hi ≠ 0).
  - DIV: ALU_Out = quotient, ALU_Hi = remainder.
  - DIV by zero: ALU_Out = all ones, ALU_Hi = A, DivZero = 1, latency 1.
  - Reserved opcode: ALU_Out = ALU_Hi = 0, Illegal = 1, isZero = 1.
  - isZero is computed from ALU_Out only.
- Flags are registered with the result and cleared on the next accept.
- Reset mid-operation (BUSY or DONE): operation abandoned, all state returns to reset values asynchronously, no result produced.
- in_valid while BUSY/DONE is ignored; the source must hold it until in_ready.

Decomposition:
- Package seq_alu_pkg:
  - opcode localparams (OP_ADD … OP_DIV).
  - FSM state encoding.
  - helper function for signed-overflow detection.
- One sub-module, seq_alu_muldiv:
  - iterative shift-add/restoring-divide datapath with start, busy, done.
  - owns the counter and partial-product/remainder registers.
- The single-cycle ops stay inline in seq_alu.

Test Plan:
- Reset, then ADD A=5, B=2 → one cycle after accept: out_valid = 1, ALU_Out = 7, Carry = 0, isZero = 0; in_ready = 1 again after out_ready.
- SUB A=16'h0003, B=16'h0005 → ALU_Out = 16'hFFFE, Carry = 1, Overflow = 0. ADD A=16'h7FFF, B=1 → ALU_Out = 16'h8000, Overflow = 1.
- MUL A=16'h1234, B=16'h0100 → out_valid exactly 17 cycles after accept, {ALU_Hi, ALU_Out} = 32'h0012_3400, Carry = 1. DIV A=100, B=7 → ALU_Out = 14, ALU_Hi = 2 after 17 cycles.
- DIV A=9, B=0 → latency 1: ALU_Out = 16'hFFFF, ALU_Hi = 9, DivZero = 1. Opcode 12 → Illegal = 1, ALU_Out = 0, isZero = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after a MUL completes → outputs stable, in_ready = 0, new in_valid ignored; release → one transfer only.
- Assert rst_n low at cycle 8 of a DIV → out_valid never rises, in_ready = 1 after reset; the next ADD 1+1 returns 2 normally.
